// File: rtl/wb_cmd_pkg.sv
// Shared types and widths for the Wishbone command master.
package wb_cmd_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } wbm_state_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone initiator fed by a valid/ready command stream.
// Optional bus-cycle abort counter is enabled by defining WBM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | stb asserted, waiting for the responder to take it (stall=0)
// WAIT  | strobe taken, cyc held until ack/err
// RESP  | response presented until consumed
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int AW      = 30,
    parameter int TIMEOUT = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_we,
    input  logic [AW-1:0]      i_cmd_addr,
    input  logic [WB_DW-1:0]   i_cmd_data,
    input  logic [WB_SELW-1:0] i_cmd_sel,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [AW-1:0]      o_wb_addr,
    output logic [WB_DW-1:0]   o_wb_data,
    output logic [WB_SELW-1:0] o_wb_sel,
    input  logic               i_wb_stall,
    input  logic               i_wb_ack,
    input  logic               i_wb_err,
    input  logic [WB_DW-1:0]   i_wb_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [WB_DW-1:0]   o_rsp_data,
    output logic               o_rsp_err,
    output logic               o_rsp_timeout
);

    wbm_state_e         state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WB_DW-1:0]   data_q, data_d;
    logic [WB_SELW-1:0] sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               complete;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        complete    = 1'b0;
`ifdef WBM_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    data_d  = i_cmd_data;
                    sel_d   = i_cmd_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ST_REQ;
`ifdef WBM_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_REQ: begin
                // ack/err only count once the strobe has actually been taken
                if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    if (i_wb_ack || i_wb_err) complete = 1'b1;
                    else                      state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_wb_ack || i_wb_err) complete = 1'b1;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            state_d     = ST_RESP;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = i_wb_err;
            rsp_data_d  = (!we_q && !i_wb_err) ? i_wb_data : '0;
`ifdef WBM_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
        end

`ifdef WBM_TIMEOUT_EN
        // a real completion on the same cycle as the limit takes precedence
        if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (!complete && (tmo_cnt_q == CNT_LIM)) begin
                state_d       = ST_RESP;
                cyc_d         = 1'b0;
                stb_d         = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_err_d     = 1'b1;
                rsp_data_d    = '0;
                rsp_timeout_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef WBM_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_rsp_timeout = rsp_timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    // held low while reset is asserted even though the state already reads IDLE
    assign o_cmd_ready = (state_q == ST_IDLE) && i_reset_n;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = data_q;
    assign o_wb_sel    = sel_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

endmodule
